// File: rtl/memory_game_ctrl_if.sv
// Game-side signal bundle for memory_game_ctrl: player controls, LFSR handshake
// and status outputs. master = the controller, slave = board top / generator.
interface memory_game_ctrl_if;
  logic       start;
  logic [3:0] btn;
  logic [1:0] rng_sig;
  logic       rng_load;
  logic [7:0] rng_seed;
  logic       rng_step;
  logic [3:0] led;
  logic [4:0] level;
  logic       busy;
  logic       win;
  logic       lose;

  modport master (
    input  start, btn, rng_sig,
    output rng_load, rng_seed, rng_step, led, level, busy, win, lose
  );

  modport slave (
    output start, btn, rng_sig,
    input  rng_load, rng_seed, rng_step, led, level, busy, win, lose
  );
endinterface

// File: rtl/memory_game_ctrl.sv
// Simon-style sequencer: seeds and steps the external LFSR, replays the stored
// quadrant sequence on the lamps, then checks the player's presses against it.
// state      | meaning                 state      | meaning
// S_IDLE     | waiting for start       S_SHOW_ON  | lamp mem[idx] lit
// S_ADD      | step the generator      S_SHOW_OFF | gap between lamps
// S_ADD_WAIT | capture new quadrant    S_INPUT    | checking presses
// S_WIN      | full sequence repeated  S_LOSE     | wrong press or timeout
module memory_game_ctrl #(
  parameter int unsigned TICK_DIV      = 50000000,
  parameter int unsigned MAX_LEN       = 16,
  parameter logic [7:0]  DEF_SEED      = 8'd13,
  parameter int unsigned TIMEOUT_TICKS = 5
) (
  input logic                clk,
  input logic                reset,
  memory_game_ctrl_if.master bus
);
  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_ADD      = 3'd1;
  localparam logic [2:0] S_ADD_WAIT = 3'd2;
  localparam logic [2:0] S_SHOW_ON  = 3'd3;
  localparam logic [2:0] S_SHOW_OFF = 3'd4;
  localparam logic [2:0] S_INPUT    = 3'd5;
  localparam logic [2:0] S_WIN      = 3'd6;
  localparam logic [2:0] S_LOSE     = 3'd7;

  localparam int          AW        = $clog2(MAX_LEN);
  localparam logic [31:0] ON_LOAD   = 32'(TICK_DIV - 1);
  localparam logic [31:0] OFF_LOAD  = 32'(TICK_DIV / 2 - 1);
  localparam logic [31:0] TO_LOAD   = 32'(TIMEOUT_TICKS * TICK_DIV - 1);
  localparam logic [4:0]  MAX_LEN_V = 5'(MAX_LEN);

  logic [2:0]  state;
  logic [4:0]  len;
  logic [4:0]  idx;
  logic [31:0] timer;
  logic [7:0]  seed_cnt;
  logic [1:0]  mem [MAX_LEN];
  logic        win_q;
  logic        lose_q;
  logic        idle_like;
  logic        last_idx;
  logic        load_now;
  logic [3:0]  want;
  logic [3:0]  led_c;

  assign idle_like = (state == S_IDLE) || (state == S_WIN) || (state == S_LOSE);
  assign last_idx  = (idx == len - 5'd1);
  assign want      = 4'b0001 << mem[idx[AW-1:0]];
  assign load_now  = !reset && bus.start && idle_like;

  always_comb begin
    led_c = 4'b0000;
    case (state)
      S_SHOW_ON: led_c = want;
      S_INPUT:   led_c = bus.btn;
      S_WIN:     led_c = 4'b1111;
      default:   led_c = 4'b0000;
    endcase
  end

  // Load and step are decoded from the current cycle so the generator has moved
  // by the time ADD_WAIT samples rng_sig.
  assign bus.rng_load = load_now;
  assign bus.rng_seed = load_now ? ((seed_cnt == 8'd0) ? DEF_SEED : seed_cnt) : 8'd0;
  assign bus.rng_step = (state == S_ADD);
  assign bus.led      = led_c;
  assign bus.level    = len;
  assign bus.busy     = !idle_like;
  assign bus.win      = win_q;
  assign bus.lose     = lose_q;

  always_ff @(posedge clk) begin
    if (state == S_ADD_WAIT) mem[len[AW-1:0]] <= bus.rng_sig;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      len      <= 5'd0;
      idx      <= 5'd0;
      timer    <= 32'd0;
      seed_cnt <= 8'd0;
      win_q    <= 1'b0;
      lose_q   <= 1'b0;
    end else begin
      seed_cnt <= seed_cnt + 8'd1;
      win_q    <= 1'b0;
      lose_q   <= 1'b0;
      case (state)
        S_IDLE, S_WIN, S_LOSE: begin
          if (bus.start) begin
            len   <= 5'd0;
            state <= S_ADD;
          end
        end
        S_ADD: state <= S_ADD_WAIT;
        S_ADD_WAIT: begin
          len   <= len + 5'd1;
          idx   <= 5'd0;
          timer <= ON_LOAD;
          state <= S_SHOW_ON;
        end
        S_SHOW_ON: begin
          if (timer == 32'd0) begin
            timer <= OFF_LOAD;
            state <= S_SHOW_OFF;
          end else begin
            timer <= timer - 32'd1;
          end
        end
        S_SHOW_OFF: begin
          if (timer != 32'd0) begin
            timer <= timer - 32'd1;
          end else if (last_idx) begin
            idx   <= 5'd0;
            timer <= TO_LOAD;
            state <= S_INPUT;
          end else begin
            idx   <= idx + 5'd1;
            timer <= ON_LOAD;
            state <= S_SHOW_ON;
          end
        end
        S_INPUT: begin
          // A press in the expiring cycle wins over the timeout.
          if (bus.btn != 4'b0000) begin
            if (bus.btn == want) begin
              timer <= TO_LOAD;
              if (!last_idx) begin
                idx <= idx + 5'd1;
              end else if (len == MAX_LEN_V) begin
                win_q <= 1'b1;
                state <= S_WIN;
              end else begin
                state <= S_ADD;
              end
            end else begin
              lose_q <= 1'b1;
              state  <= S_LOSE;
            end
          end else if (timer == 32'd0) begin
            lose_q <= 1'b1;
            state  <= S_LOSE;
          end else begin
            timer <= timer - 32'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_memory_game_ctrl.sv
// Scoreboard bench for memory_game_ctrl: a game-level model pushes the expected
// output of every active cycle; a negedge monitor pops and compares.
module tb_memory_game_ctrl;
  localparam int TICK    = 4;
  localparam int MAXL    = 3;
  localparam int TO_T    = 2;
  localparam int ON_CYC  = TICK;
  localparam int OFF_CYC = TICK / 2;
  localparam int TO_CYC  = TO_T * TICK;

  typedef struct {
    string       tag;
    int          cyc;
    logic [21:0] vec;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start_d = 1'b0;
  logic [3:0] btn_d = 4'h0;
  logic [1:0] sig_q = 2'd0;

  memory_game_ctrl_if bus();
  assign bus.start   = start_d;
  assign bus.btn     = btn_d;
  assign bus.rng_sig = sig_q;

  memory_game_ctrl #(
    .TICK_DIV(TICK), .MAX_LEN(MAXL), .DEF_SEED(8'd13), .TIMEOUT_TICKS(TO_T)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  int cycle = 0;
  int seed_base = 0;
  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;
  bit gen_random = 1'b0;
  logic [1:0] gen_k = 2'd0;
  logic [1:0] gen_last = 2'd0;
  logic [1:0] gen_v;
  logic [1:0] script [3] = '{2'd2, 2'd0, 2'd3};
  logic [4:0] level_m = 5'd0;
  bit prev_won = 1'b0;
  exp_t sb[$];

  always @(posedge clk) cycle <= cycle + 1;

  // Generator model: reload restarts the script, each step presents the next value.
  always @(posedge clk) begin
    if (bus.rng_load) gen_k <= 2'd0;
    if (bus.rng_step) begin
      gen_v = gen_random ? 2'($urandom_range(0, 3)) : script[gen_k];
      sig_q    <= gen_v;
      gen_last <= gen_v;
      gen_k    <= (gen_k == 2'd2) ? 2'd0 : gen_k + 2'd1;
    end
  end

  always @(negedge clk) begin
    logic [21:0] got;
    exp_t e;
    if (mon_en && (bus.busy || bus.win || bus.lose || bus.rng_load || bus.rng_step)) begin
      got = {bus.led, bus.level, bus.busy, bus.win, bus.lose, bus.rng_load, bus.rng_seed, bus.rng_step};
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output cycle %0d: got %h, nothing expected", cycle, got);
      end else begin
        e = sb.pop_front();
        if (e.cyc != cycle || e.vec !== got)
          begin
            errors++;
            $display("FAIL %s cycle %0d: got %h, expected %h at cycle %0d", e.tag, cycle, got, e.vec, e.cyc);
          end
      end
    end
  end

  function automatic logic [3:0] oh(input logic [1:0] q);
    return 4'b0001 << q;
  endfunction

  function automatic logic rs();
    return ($urandom_range(0, 5) == 0);
  endfunction

  function automatic logic [3:0] rb();
    return 4'($urandom_range(0, 15));
  endfunction

  function automatic logic [21:0] mk(input logic [3:0] led, input logic [4:0] lvl,
                                     input logic busy, input logic win, input logic lose,
                                     input logic load, input logic [7:0] seed, input logic step);
    return {led, lvl, busy, win, lose, load, seed, step};
  endfunction

  task automatic push(input string tag, input logic [21:0] v);
    exp_t e;
    e.tag = tag;
    e.cyc = cycle;
    e.vec = v;
    sb.push_back(e);
  endtask

  task automatic drive(input logic s, input logic [3:0] b);
    @(posedge clk);
    #1;
    start_d = s;
    btn_d   = b;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, rb());
  endtask

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // fail_kind: 0 none, 1 wrong single lamp, 2 extra lamp, 3 timeout. delay<0 = random gaps.
  task automatic play_game(input bit now, input int fail_round, input int fail_press,
                           input int fail_kind, input int delay, input bit abort_show);
    logic [1:0] seq [$];
    logic [7:0] sd;
    logic [3:0] b;
    int d;
    bit failing;
    if (now) begin
      start_d = 1'b1;
      btn_d   = 4'h0;
    end else begin
      drive(1'b1, 4'h0);
    end
    sd = 8'(cycle - seed_base);
    if (sd == 8'd0) sd = 8'd13;
    push("load", mk(prev_won ? 4'hF : 4'h0, level_m, 1'b0, 1'b0, 1'b0, 1'b1, sd, 1'b0));
    for (int r = 1; r <= MAXL; r++) begin
      drive(rs(), rb());
      push("step", mk(4'h0, 5'(r - 1), 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1));
      drive(rs(), rb());
      push("capture", mk(4'h0, 5'(r - 1), 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0));
      seq.push_back(gen_last);
      level_m = 5'(r);
      for (int k = 0; k < r; k++) begin
        for (int t = 0; t < ON_CYC; t++) begin
          if (abort_show && t == 2) begin
            drive(1'b0, 4'h0);
            reset = 1'b1;
            push("show_on", mk(oh(seq[k]), level_m, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0));
            drive(1'b0, 4'h0);
            reset = 1'b0;
            seed_base = cycle;
            level_m = 5'd0;
            prev_won = 1'b0;
            @(negedge clk);
            chk("abort_led", 8'(bus.led), 8'h00);
            chk("abort_level", 8'(bus.level), 8'h00);
            chk("abort_busy", 8'(bus.busy), 8'h00);
            chk("abort_win_lose", 8'({bus.win, bus.lose}), 8'h00);
            return;
          end
          drive(abort_show && t == 1, rb());
          push("show_on", mk(oh(seq[k]), level_m, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0));
        end
        for (int t = 0; t < OFF_CYC; t++) begin
          drive(rs(), rb());
          push("show_off", mk(4'h0, level_m, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0));
        end
      end
      for (int j = 0; j < r; j++) begin
        failing = (r == fail_round) && (j == fail_press);
        d = (delay >= 0) ? delay : int'($urandom_range(0, TO_CYC - 1));
        if (failing && fail_kind == 3) d = TO_CYC;
        for (int i = 0; i < d; i++) begin
          drive(rs(), 4'h0);
          push("wait", mk(4'h0, level_m, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0));
        end
        if (failing && fail_kind == 3) begin
          drive(1'b0, 4'h0);
          push("timeout_lose", mk(4'h0, level_m, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0));
          prev_won = 1'b0;
          return;
        end
        b = oh(seq[j]);
        if (failing && fail_kind == 1) b = oh(seq[j] + 2'd1);
        if (failing && fail_kind == 2) b = oh(seq[j]) | oh(seq[j] + 2'd2);
        drive(rs(), b);
        push("press", mk(b, level_m, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0));
        if (failing && fail_kind != 0) begin
          drive(1'b0, 4'h0);
          push("wrong_lose", mk(4'h0, level_m, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0));
          prev_won = 1'b0;
          return;
        end
        if (j == r - 1 && r == MAXL) begin
          drive(1'b0, 4'h0);
          push("win", mk(4'hF, 5'(MAXL), 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0));
          prev_won = 1'b1;
          return;
        end
      end
    end
  endtask

  initial begin
    int fr;
    int fp;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_led", 8'(bus.led), 8'h00);
    chk("reset_level", 8'(bus.level), 8'h00);
    chk("reset_flags", 8'({bus.busy, bus.win, bus.lose, bus.rng_load, bus.rng_step}), 8'h00);
    chk("reset_seed", bus.rng_seed, 8'h00);
    @(posedge clk);
    #1;
    reset = 1'b0;
    seed_base = cycle;
    mon_en = 1'b1;

    // Scripted generator 2,0,3: full correct game from seed counter 0.
    play_game(1'b1, 0, 0, 0, -1, 1'b0);
    idle(4);
    @(negedge clk);
    chk("win_hold_led", 8'(bus.led), 8'h0F);
    chk("win_hold_level", 8'(bus.level), 8'd3);
    chk("win_hold_flags", 8'({bus.busy, bus.win, bus.lose}), 8'h00);

    play_game(1'b0, 2, 1, 1, -1, 1'b0);
    idle(3);
    @(negedge clk);
    chk("lose_hold_led", 8'(bus.led), 8'h00);
    chk("lose_hold_level", 8'(bus.level), 8'd2);

    play_game(1'b0, 1, 0, 3, -1, 1'b0);
    idle(3);
    @(negedge clk);
    chk("timeout_level", 8'(bus.level), 8'd1);

    play_game(1'b0, 0, 0, 0, TO_CYC - 1, 1'b0);
    idle(2);
    play_game(1'b0, 1, 0, 2, -1, 1'b0);
    idle(2);
    play_game(1'b0, 0, 0, 0, -1, 1'b1);
    idle(3);

    gen_random = 1'b1;
    for (int g = 0; g < 20; g++) begin
      fr = int'($urandom_range(0, MAXL));
      fp = (fr > 0) ? int'($urandom_range(0, fr - 1)) : 0;
      play_game(1'b0, fr, fp, int'($urandom_range(1, 3)), -1, 1'b0);
      idle(int'($urandom_range(1, 40)));
    end

    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL leftover_expected: got %0d pending, expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/memory_game_ctrl.md
Name: memory_game_ctrl

Overview:
- Sequencer for a Simon-style memory game built around the board's 8-bit LFSR random generator; the generator instantiation stays outside this block.
- Seeds the generator and requests one 2-bit quadrant value per round, then stores it in a sequence buffer.
- Replays the sequence on 4 LEDs at a slow display rate, then checks the player's button presses against it.
- Reports level, win and lose to the top level, which drives the 7-segment display.

Parameters:
- TICK_DIV, 50000000, clk cycles per LED-on step (1 s at 50 MHz); LED-off gap is TICK_DIV/2.
- MAX_LEN, 16, sequence length that wins the game (2..31).
- DEF_SEED, 8'd13, seed used when the captured seed is zero.
- TIMEOUT_TICKS, 5, input timeout in units of TICK_DIV cycles.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  single-cycle pulse that starts a new game
- btn  in  4  debounced single-cycle press pulses, bit i = quadrant i
- rng_sig  in  2  quadrant output of the random generator
- rng_load  out  1  one-cycle pulse: generator loads rng_seed
- rng_seed  out  8  seed value, valid while rng_load=1
- rng_step  out  1  one-cycle pulse: generator advances once
- led  out  4  quadrant lamps
- level  out  5  current sequence length (score)
- busy  out  1  high in all states except IDLE, WIN and LOSE
- win  out  1  one-cycle pulse on entry to WIN
- lose  out  1  one-cycle pulse on entry to LOSE

Behaviour:
- Reset: all outputs 0. State goes to IDLE; len, idx, timers and the free-running seed counter all clear to 0. Reset mid-game aborts with no win or lose pulse.
- The 8-bit seed counter increments every cycle in every state.
- IDLE, WIN or LOSE + start:
  - rng_load=1 for 1 cycle; rng_seed = seed counter value, or DEF_SEED if that value is 0.
  - len=0 -> ADD.
- start while busy is ignored.
- ADD: rng_step=1 for 1 cycle -> ADD_WAIT.
- ADD_WAIT (1 cycle):
  - rng_sig is valid here (generator updates on the edge after rng_step). It is written to mem[len].
  - len<=len+1, idx<=0, timer<=0 -> SHOW_ON.
  - level follows len (registered).
- SHOW_ON: led = onehot(mem[idx]) for exactly TICK_DIV cycles -> SHOW_OFF.
- SHOW_OFF: led=0 for TICK_DIV/2 cycles.
  - If idx==len-1: idx<=0, timer<=0 -> INPUT.
  - Else: idx<=idx+1 -> SHOW_ON.
- INPUT: led = btn (lamp echo).
  - btn==0: timer counts. At TIMEOUT_TICKS*TICK_DIV cycles -> LOSE.
  - btn == onehot(mem[idx]): timer<=0.
    - If idx==len-1: -> WIN if len==MAX_LEN, else -> ADD.
    - Else: idx<=idx+1.
  - Wrong bit, or more than one bit set: -> LOSE.
  - btn arriving in the same cycle the timeout expires is evaluated as a press; timeout is ignored.
- btn pulses outside INPUT are ignored.
- WIN: win=1 on entry cycle only; led=4'b1111 held; level holds MAX_LEN.
- LOSE: lose=1 on entry cycle only; led=4'b0000; level holds the length reached.
- The sequence buffer is MAX_LEN x 2-bit registers. It is not cleared on a new game; len bounds every access.
- First LED-on begins 3 cycles after start is sampled (load, step, capture).
- rng_load and rng_step are never high in the same cycle.

Test Plan:
- Bench setup: TICK_DIV=4, MAX_LEN=3, TIMEOUT_TICKS=2. Generator is a bench model returning a scripted rng_sig sequence 2,0,3 after each step.
- Reset then start at a seed-counter value of 0x00:
  - rng_load with rng_seed=0x0D, then rng_step next cycle.
  - led=4'b0100 for 4 cycles, then 0 for 2 cycles; level=1.
- Correct play through all 3 rounds (press 0100; then 0100, 0001; then 0100, 0001, 1000):
  - Each round replays the full prefix.
  - win pulses once; led=1111; level=3; busy=0.
- Round 2, press 0010 instead of 0001 -> lose pulses 1 cycle; led=0; level=2.
- In INPUT, no press for 8 cycles -> LOSE at exactly cycle 8. A press landing on cycle 8 is accepted instead.
- In INPUT, btn=0101 -> LOSE.
- reset asserted during SHOW_ON -> next cycle state IDLE, led=0, level=0, no win or lose pulse. A start during SHOW_ON before the reset is ignored.
